// File: rtl/counter_pkg.sv
// Shared definitions for the shift-register counter sequencer.
// Holds the counter mode encodings, the sequencer state enum and the default
// LFSR feedback mask used when the register is 4 bits wide.
package counter_pkg;

    // Counter flavour applied on every step.
    typedef enum logic [1:0] {
        MODE_LFSR    = 2'b00,
        MODE_RING    = 2'b01,
        MODE_JOHNSON = 2'b10,
        MODE_BIN     = 2'b11
    } mode_t;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int         DEFAULT_WIDTH = 4;
    localparam logic [3:0] DEFAULT_TAPS  = 4'b0011;

endpackage

// File: rtl/shift_counter_sequencer_if.sv
// Control/status bundle between a run requester and the sequencer.
//   start/abort/pause : run control (requester -> sequencer)
//   mode/seed/steps   : run configuration, sampled on the start edge
//   q/step_cnt        : register state and steps applied so far
//   busy/done/lockup  : registered status flags
// master = requester side, slave = sequencer side.
interface shift_counter_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    import counter_pkg::*;

    logic             start;
    logic             abort;
    logic             pause;
    mode_t            mode;
    logic [WIDTH-1:0] seed;
    logic [CNT_W-1:0] steps;
    logic [WIDTH-1:0] q;
    logic [CNT_W-1:0] step_cnt;
    logic             busy;
    logic             done;
    logic             lockup;

    modport master (
        output start, abort, pause, mode, seed, steps,
        input  q, step_cnt, busy, done, lockup
    );

    modport slave (
        input  start, abort, pause, mode, seed, steps,
        output q, step_cnt, busy, done, lockup
    );

endinterface

// File: rtl/shift_counter_sequencer_next.sv
// shift_counter_next: purely combinational next-state function of the
// shift-register counter. Also usable on its own as a golden model for the
// DFF-chain counter benches.
//   q    : current register value (q[WIDTH-1] is the MSB)
//   mode : counter flavour
//   nxt  : value the register takes on the next step
module shift_counter_next
    import counter_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input  logic [WIDTH-1:0] q,
    input  mode_t            mode,
    output logic [WIDTH-1:0] nxt
);

    // Every flavour except binary shifts right by one; only the bit
    // entering at the MSB differs.
    always_comb begin
        nxt = q;
        case (mode)
            MODE_LFSR:    nxt = {^(q & TAPS), q[WIDTH-1:1]};
            MODE_RING:    nxt = {q[0], q[WIDTH-1:1]};
            MODE_JOHNSON: nxt = {~q[0], q[WIDTH-1:1]};
            MODE_BIN:     nxt = q + WIDTH'(1);
            default:      nxt = q;
        endcase
    end

endmodule

// File: rtl/shift_counter_sequencer.sv
// shift_counter_sequencer: seeds a WIDTH-bit shift-register counter, steps it
// a programmed number of times and reports completion.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of shift_counter_sequencer_if (control in, status out)
// An LFSR run with an all-zero seed would never leave zero, so it finishes
// immediately with lockup raised instead of stepping.
module shift_counter_sequencer
    import counter_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter int               CNT_W = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS)
) (
    input logic                      clk,
    input logic                      rst,
    shift_counter_sequencer_if.slave bus
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_reg, q_next, q_step;
    logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
    logic [CNT_W-1:0] steps_reg, steps_next;
    mode_t            mode_reg, mode_next;
    logic             lockup_reg, lockup_next;

    logic start_ok;
    logic seed_lockup;
    logic last_step;

    // The step function always works on the latched mode so that the mode
    // input may change freely during a run.
    shift_counter_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .q    (q_reg),
        .mode (mode_reg),
        .nxt  (q_step)
    );

    assign start_ok    = bus.start && !bus.abort &&
                         ((state_reg == IDLE) || (state_reg == DONE));
    assign seed_lockup = (bus.mode == MODE_LFSR) && (bus.seed == '0);
    assign cnt_inc     = cnt_reg + CNT_W'(1);
    assign last_step   = (cnt_inc == steps_reg);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        if (bus.abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        if (seed_lockup || (bus.steps == '0)) begin
                            state_next = DONE;
                        end else begin
                            state_next = RUN;
                        end
                    end
                end
                RUN: begin
                    // Finish on the edge that applies the last step.
                    if (!bus.pause && last_step) begin
                        state_next = DONE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs (decoded from registered state) ----------------
    assign bus.busy   = (state_reg == RUN);
    assign bus.done   = (state_reg == DONE);
    assign bus.lockup = (state_reg == DONE) && lockup_reg;

    // ---------------- Datapath ----------------
    always_comb begin
        q_next      = q_reg;
        cnt_next    = cnt_reg;
        mode_next   = mode_reg;
        steps_next  = steps_reg;
        lockup_next = lockup_reg;
        if (start_ok) begin
            mode_next   = bus.mode;
            steps_next  = bus.steps;
            q_next      = bus.seed;
            cnt_next    = '0;
            lockup_next = seed_lockup;
        end else if (!bus.abort && (state_reg == RUN) && !bus.pause) begin
            q_next   = q_step;
            cnt_next = cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg      <= '0;
            cnt_reg    <= '0;
            mode_reg   <= MODE_LFSR;
            steps_reg  <= '0;
            lockup_reg <= 1'b0;
        end else begin
            q_reg      <= q_next;
            cnt_reg    <= cnt_next;
            mode_reg   <= mode_next;
            steps_reg  <= steps_next;
            lockup_reg <= lockup_next;
        end
    end

    assign bus.q        = q_reg;
    assign bus.step_cnt = cnt_reg;

endmodule

// File: tb/tb_shift_counter_sequencer.sv
// Scoreboard bench for shift_counter_sequencer: each run pushes its expected
// completion (final q, step count, lockup, completion cycle) into a queue; a
// monitor pops and compares whenever done rises.
module tb_shift_counter_sequencer;
    import counter_pkg::*;

    localparam int W    = 4;
    localparam int CW   = 8;
    localparam int TAPS = 'b0011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    typedef struct {
        int q;
        int cnt;
        int lock;
        int cyc;
    } exp_t;

    exp_t sb[$];

    shift_counter_sequencer_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    shift_counter_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference step function, written from the counter definitions.
    function automatic int nxt_model(input int m, input int s);
        int fb;
        case (m)
            0: begin
                fb = 0;
                for (int b = 0; b < W; b++)
                    if (((TAPS >> b) & 1) == 1) fb = fb ^ ((s >> b) & 1);
                return (fb << (W - 1)) | (s >> 1);
            end
            1: return ((s & 1) << (W - 1)) | (s >> 1);
            2: return (((~s) & 1) << (W - 1)) | (s >> 1);
            default: return (s + 1) % (1 << W);
        endcase
    endfunction

    function automatic int model_steps(input int m, input int s, input int n);
        int v = s;
        for (int i = 0; i < n; i++) v = nxt_model(m, v);
        return v;
    endfunction

    // Monitor: compares on every rising edge of done.
    bit done_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            done_prev = 1'b0;
        end else begin
            if (bus.done && !done_prev) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_q", 32'(bus.q), 32'(e.q));
                    check("done_cnt", 32'(bus.step_cnt), 32'(e.cnt));
                    check("done_lockup", 32'(bus.lockup), 32'(e.lock));
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    check("done_busy", 32'(bus.busy), 32'd0);
                end
            end
            done_prev = bus.done;
        end
    end

    task automatic drain();
        for (int t = 0; t < 3 && sb.size() != 0; t++) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // One run: pause held for p cycles starting after k steps (k < n).
    task automatic run(input int m, input int sd, input int n, input int k, input int p);
        bit   instant;
        int   len;
        int   applied;
        exp_t e;
        instant = ((m == 0) && (sd == 0)) || (n == 0);
        // An instant run started from DONE would leave done high throughout.
        if (instant && bus.done) begin
            @(negedge clk);
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.pause = 1'b0;
        bus.mode  = mode_t'(m);
        bus.seed  = W'(sd);
        bus.steps = CW'(n);
        if (instant) begin
            e.q = sd; e.cnt = 0; e.lock = ((m == 0) && (sd == 0)) ? 1 : 0; len = 0;
        end else begin
            e.q = model_steps(m, sd, n); e.cnt = n; e.lock = 0; len = n + p;
        end
        e.cyc = cyc + 1 + len;
        sb.push_back(e);
        $display("run mode=%0d seed=%h steps=%0d pause=%0d@%0d expect q=%h lockup=%0d",
                 m, sd, n, p, k, e.q, e.lock);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            applied = i - ((i <= k) ? 0 : ((i < k + p) ? (i - k) : p));
            check("trace_q", 32'(bus.q), 32'(model_steps(m, sd, applied)));
            check("trace_cnt", 32'(bus.step_cnt), 32'(applied));
            check("trace_busy", 32'(bus.busy), 32'd1);
            // Configuration and start are ignored while running.
            bus.start = 1'($urandom_range(0, 1));
            bus.mode  = mode_t'($urandom_range(0, 3));
            bus.seed  = W'($urandom);
            bus.steps = CW'($urandom);
            bus.pause = ((i >= k) && (i < k + p)) ? 1'b1 : 1'b0;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.pause = 1'b0;
        drain();
    endtask

    // Run aborted after k steps (1 <= k < n, non-lockup seed).
    task automatic abort_run(input int m, input int sd, input int n, input int k);
        int exp_q;
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = mode_t'(m);
        bus.seed  = W'(sd);
        bus.steps = CW'(n);
        for (int i = 0; i <= k; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        exp_q = model_steps(m, sd, k);
        $display("abort mode=%0d seed=%h steps=%0d after=%0d expect q=%h", m, sd, n, k, exp_q);
        check("pre_abort_busy", 32'(bus.busy), 32'd1);
        bus.abort = 1'b1;
        bus.start = 1'b1;   // abort must win over start
        @(negedge clk);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_q", 32'(bus.q), 32'(exp_q));
        check("abort_cnt", 32'(bus.step_cnt), 32'(k));
        @(negedge clk);
        check("abort_hold_q", 32'(bus.q), 32'(exp_q));
        check("abort_hold_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int m, sd, n, k, p;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.pause = 1'b0;
        bus.mode  = MODE_LFSR;
        bus.seed  = '0;
        bus.steps = '0;
        repeat (2) @(negedge clk);
        check("rst_q", 32'(bus.q), 32'd0);
        check("rst_cnt", 32'(bus.step_cnt), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_lockup", 32'(bus.lockup), 32'd0);
        rst = 1'b0;

        run(0, 'b0100, 4, 0, 0);     // LFSR sequence
        run(0, 'b0000, 10, 0, 0);    // LFSR lockup
        run(2, 'b0000, 8, 0, 0);     // Johnson full period
        run(1, 'b0001, 4, 0, 0);     // ring full period
        run(3, 'b1110, 5, 1, 3);     // binary wrap with pause
        abort_run(3, 'b0011, 10, 4);
        run(2, 'b0101, 0, 0, 0);     // zero steps
        run(1, 'b1000, 3, 0, 0);
        run(0, 'b1011, 6, 2, 2);     // restarted directly from DONE

        for (int r = 0; r < 40; r++) begin
            m  = $urandom_range(0, 3);
            sd = $urandom_range(0, (1 << W) - 1);
            n  = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 40) : $urandom_range(0, 12);
            if (n >= 2 && !(m == 0 && sd == 0) && $urandom_range(0, 5) == 0) begin
                abort_run(m, sd, n, $urandom_range(1, n - 1));
            end else begin
                k = (n > 0) ? $urandom_range(0, n - 1) : 0;
                p = (n > 0) ? $urandom_range(0, 3) : 0;
                run(m, sd, n, k, p);
            end
        end

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = MODE_BIN;
        bus.seed  = W'(5);
        bus.steps = CW'(20);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        $display("async reset mid-run");
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_q", 32'(bus.q), 32'd0);
        check("arst_cnt", 32'(bus.step_cnt), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_lockup", 32'(bus.lockup), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run(3, 'b0111, 3, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_counter_sequencer.md
Name: shift_counter_sequencer

Overview:
- Controller that seeds, configures and steps a WIDTH-bit shift-register counter for a programmed number of clocks, then reports completion.
- Wraps the DFF-chain counter the team builds (LFSR, ring, Johnson, binary) behind a start/busy/done handshake, so benches and higher blocks need not hand-drive the D inputs.
- The register stays internal; its state is exposed on q.

Parameters:
- WIDTH, 4, counter register width (minimum 2).
- CNT_W, 8, width of the step count and step counter.
- TAPS, 4'b0011, LFSR feedback mask of WIDTH bits: feedback = XOR of (q AND TAPS).

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-high.
- start  input  1  request a run; sampled only in IDLE or DONE.
- abort  input  1  force return to IDLE.
- pause  input  1  hold the register and count while in RUN.
- mode  input  2  00 LFSR, 01 ring, 10 Johnson, 11 binary up; latched at start.
- seed  input  WIDTH  initial register value; latched at start.
- steps  input  CNT_W  number of steps to apply; latched at start.
- q  output  WIDTH  current register state.
- step_cnt  output  CNT_W  number of steps applied in the current or last run.
- busy  output  1  high in RUN.
- done  output  1  high in DONE.
- lockup  output  1  high in DONE when the run ended because LFSR mode had an all-zero seed.

Behaviour:
- Reset (async assert, any state):
  - state=IDLE; q=0, step_cnt=0, busy=0, done=0, lockup=0.
  - Latched mode and steps registers cleared.
  - Release is synchronous to the next CLK edge.
- States are IDLE, RUN and DONE. Outputs are registered: busy=(state==RUN), done=(state==DONE).
- Next-state function nxt(q), with q[WIDTH-1] as MSB:
  - LFSR: {^(q&TAPS), q[WIDTH-1:1]}. With WIDTH=4 and TAPS=0011 this is D3=Q1^Q0, D2=Q3, D1=Q2, D0=Q1.
  - Ring: {q[0], q[WIDTH-1:1]}.
  - Johnson: {~q[0], q[WIDTH-1:1]}.
  - Binary: q+1, wrapping modulo 2^WIDTH.
- Start in IDLE or DONE, at edge E with start=1 and abort=0:
  - Latch mode and steps; q<=seed; step_cnt<=0; lockup<=0.
  - If mode==LFSR and seed==0: go to DONE with lockup=1 (no steps applied).
  - Else if steps==0: go to DONE.
  - Else: go to RUN.
- RUN, each edge with pause=0 and abort=0:
  - q<=nxt(q); step_cnt<=step_cnt+1.
  - If step_cnt+1==latched steps, go to DONE on the same edge.
  - Latency: with no pauses, q holds the final value and done=1 after edge E+steps.
- RUN with pause=1: q, step_cnt and state hold; busy stays 1.
- abort=1 at any edge, in any state: go to IDLE with busy=0 and done=0. q and step_cnt hold their values. abort has priority over start and pause.
- DONE: q and step_cnt hold until the next start. start in DONE starts a new run directly (DONE->RUN; busy rises on the next edge).
- start while in RUN: ignored. Inputs mode, seed and steps are ignored outside the start edge.
- step_cnt never wraps within a run, because steps ≤ 2^CNT_W−1.

Decomposition:
- Shared package counter_pkg:
  - mode encodings MODE_LFSR, MODE_RING, MODE_JOHNSON, MODE_BIN;
  - state enum IDLE, RUN, DONE;
  - default TAPS constant.
- One sub-module, shift_counter_next:
  - purely combinational nxt(q, mode) with parameters WIDTH and TAPS.
  - Reusable by the DFF-chain benches as a golden model.

Test Plan:
- LFSR run: mode=00, seed=0100, steps=4 → q sequence 0100, 0010, 1001, 1100, 0110. done=1 exactly 5 edges after start; step_cnt=4.
- LFSR lockup: mode=00, seed=0000, steps=10 → DONE one edge after start with lockup=1, busy never 1, q=0000, step_cnt=0.
- Johnson and ring:
  - mode=10, seed=0000, steps=8 → 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000 (period 8), ending at q=0000.
  - mode=01, seed=0001, steps=4 → ends at q=0001.
- Pause and abort:
  - Binary mode, seed=1110, steps=5, pause held for 3 cycles after step 1 → q wraps 1111, 0000, …, final q=0011. done is delayed exactly 3 cycles.
  - Separate run with abort mid-RUN → IDLE next edge, q frozen, done=0.
- Edge cases:
  - steps=0 → done the edge after start with q=seed.
  - start during RUN → ignored.
  - start while in DONE → re-seeds and runs again.
  - RST asserted mid-RUN between clock edges → all outputs 0 immediately, without waiting for a CLK edge.
